// File: rtl/counter_datapath_if.sv
// ---------------------------------------------------------------------------
// counter_datapath_if: controller strobes and datapath status/outputs (rev 1.0)
// oOutBcd is present only when COUNTER_DP_BCD_EN is defined.
// ---------------------------------------------------------------------------
`default_nettype none

interface counter_datapath_if #(
  parameter int WIDTH = 8
);
  logic             iAsrcSel;
  logic             iALoad;
  logic             iOutBufSel;
  logic             oAlt10;
  logic [WIDTH-1:0] oOutBuf;
  logic             oOutValid;
  logic [WIDTH-1:0] oCapCnt;
  logic             oWrapErr;
`ifdef COUNTER_DP_BCD_EN
  logic [11:0]      oOutBcd;
`endif

  modport master (
    output iAsrcSel, iALoad, iOutBufSel,
`ifdef COUNTER_DP_BCD_EN
    input  oOutBcd,
`endif
    input  oAlt10, oOutBuf, oOutValid, oCapCnt, oWrapErr
  );

  modport slave (
    input  iAsrcSel, iALoad, iOutBufSel,
`ifdef COUNTER_DP_BCD_EN
    output oOutBcd,
`endif
    output oAlt10, oOutBuf, oOutValid, oCapCnt, oWrapErr
  );
endinterface

`default_nettype wire

// File: rtl/counter_datapath.sv
// ---------------------------------------------------------------------------
// counter_datapath: accumulator A, limit compare, output buffer, capture debug.
// Optional BCD copy of the buffer via COUNTER_DP_BCD_EN.  Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module counter_datapath #(
  parameter int WIDTH = 8,
  parameter int LIMIT = 10
) (
  input  wire logic         iClk,
  input  wire logic         iRst,
  counter_datapath_if.slave dp
);

  localparam logic [WIDTH-1:0] c_LIMIT    = WIDTH'(LIMIT);
  localparam logic [WIDTH-1:0] c_ALL_ONES = {WIDTH{1'b1}};

  generate
    if (LIMIT < 1 || 64'(LIMIT) >= (64'd1 << WIDTH)) begin : g_limit_range_err
      $error("counter_datapath: LIMIT must be in 1 .. 2**WIDTH-1");
    end
  endgenerate

  logic [WIDTH-1:0] a_q, a_d;
  logic [WIDTH-1:0] buf_q, buf_d;
  logic [WIDTH-1:0] cap_q, cap_d;
  logic             valid_q, valid_d;
  logic             wrap_q, wrap_d;

`ifdef COUNTER_DP_BCD_EN
  generate
    if (WIDTH > 8) begin : g_bcd_width_err
      $error("counter_datapath: COUNTER_DP_BCD_EN requires WIDTH <= 8");
    end
  endgenerate

  logic [11:0] bcd_q, bcd_d;

  // Shift-and-add-3 conversion of an 8-bit value into three BCD digits.
  function automatic logic [11:0] to_bcd(input logic [7:0] v);
    logic [19:0] sh;
    sh = {12'd0, v};
    for (int k = 0; k < 8; k++) begin
      if (sh[11:8]  >= 4'd5) sh[11:8]  = sh[11:8]  + 4'd3;
      if (sh[15:12] >= 4'd5) sh[15:12] = sh[15:12] + 4'd3;
      if (sh[19:16] >= 4'd5) sh[19:16] = sh[19:16] + 4'd3;
      sh = sh << 1;
    end
    return sh[19:8];
  endfunction
`endif

  always_comb begin
    a_d     = a_q;
    buf_d   = buf_q;
    cap_d   = cap_q;
    valid_d = dp.iOutBufSel;
    wrap_d  = wrap_q;
`ifdef COUNTER_DP_BCD_EN
    bcd_d   = bcd_q;
`endif
    if (dp.iALoad) begin
      a_d = dp.iAsrcSel ? a_q + WIDTH'(1) : '0;
      if (dp.iAsrcSel && a_q == c_ALL_ONES) begin
        wrap_d = 1'b1;
      end
    end
    // Capture samples A as it was before this edge, even when A also loads.
    if (dp.iOutBufSel) begin
      buf_d = a_q;
      if (cap_q != c_ALL_ONES) begin
        cap_d = cap_q + WIDTH'(1);
      end
`ifdef COUNTER_DP_BCD_EN
      bcd_d = to_bcd(8'(a_q));
`endif
    end
  end

  always_ff @(posedge iClk) begin
    if (iRst) begin
      a_q     <= '0;
      buf_q   <= '0;
      cap_q   <= '0;
      valid_q <= 1'b0;
      wrap_q  <= 1'b0;
`ifdef COUNTER_DP_BCD_EN
      bcd_q   <= '0;
`endif
    end else begin
      a_q     <= a_d;
      buf_q   <= buf_d;
      cap_q   <= cap_d;
      valid_q <= valid_d;
      wrap_q  <= wrap_d;
`ifdef COUNTER_DP_BCD_EN
      bcd_q   <= bcd_d;
`endif
    end
  end

  assign dp.oAlt10    = (a_q < c_LIMIT);
  assign dp.oOutBuf   = buf_q;
  assign dp.oOutValid = valid_q;
  assign dp.oCapCnt   = cap_q;
  assign dp.oWrapErr  = wrap_q;
`ifdef COUNTER_DP_BCD_EN
  assign dp.oOutBcd   = bcd_q;
`endif

endmodule

`default_nettype wire

// File: tb/tb_counter_datapath.sv
// ---------------------------------------------------------------------------
// tb_counter_datapath: two instances (WIDTH 8 and 4, LIMIT 10) driven with the
// same directed and random strobes, checked against an arithmetic model. Rev 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_counter_datapath;

  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  counter_datapath_if #(.WIDTH(8)) if8 ();
  counter_datapath_if #(.WIDTH(4)) if4 ();

  counter_datapath #(.WIDTH(8), .LIMIT(10)) u_dut8 (.iClk(clk), .iRst(rst), .dp(if8.slave));
  counter_datapath #(.WIDTH(4), .LIMIT(10)) u_dut4 (.iClk(clk), .iRst(rst), .dp(if4.slave));

  int n_checks = 0;
  int n_fail   = 0;

  // Model state: index 0 is the 8-bit instance, index 1 the 4-bit one.
  int m_a[2], m_buf[2], m_caps[2], m_wrap[2], m_valid[2];
  int m_max[2] = '{255, 15};

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h) expected %0d (0x%0h) at %0t", tag, got, got, exp, exp, $time);
    end
  endtask

  function automatic int bcd_of(input int v);
    return ((v / 100) << 8) | (((v / 10) % 10) << 4) | (v % 10);
  endfunction

  function automatic int sat_caps(input int d);
    return (m_caps[d] > m_max[d]) ? m_max[d] : m_caps[d];
  endfunction

  task automatic model_edge(input bit r, input bit sel, input bit load, input bit cap);
    for (int d = 0; d < 2; d++) begin
      if (r) begin
        m_a[d] = 0; m_buf[d] = 0; m_caps[d] = 0; m_wrap[d] = 0; m_valid[d] = 0;
      end else begin
        m_valid[d] = cap;
        if (cap) begin
          m_buf[d] = m_a[d];
          m_caps[d]++;
        end
        if (load) begin
          if (sel) begin
            if (m_a[d] == m_max[d]) m_wrap[d] = 1;
            m_a[d] = (m_a[d] + 1) % (m_max[d] + 1);
          end else begin
            m_a[d] = 0;
          end
        end
      end
    end
  endtask

  task automatic check_all();
    check("alt8",   32'(if8.oAlt10),    32'(m_a[0] < 10));
    check("buf8",   32'(if8.oOutBuf),   32'(m_buf[0]));
    check("valid8", 32'(if8.oOutValid), 32'(m_valid[0]));
    check("cap8",   32'(if8.oCapCnt),   32'(sat_caps(0)));
    check("wrap8",  32'(if8.oWrapErr),  32'(m_wrap[0]));
    check("alt4",   32'(if4.oAlt10),    32'(m_a[1] < 10));
    check("buf4",   32'(if4.oOutBuf),   32'(m_buf[1]));
    check("valid4", 32'(if4.oOutValid), 32'(m_valid[1]));
    check("cap4",   32'(if4.oCapCnt),   32'(sat_caps(1)));
    check("wrap4",  32'(if4.oWrapErr),  32'(m_wrap[1]));
`ifdef COUNTER_DP_BCD_EN
    check("bcd8",   32'(if8.oOutBcd),   32'(bcd_of(m_buf[0])));
    check("bcd4",   32'(if4.oOutBcd),   32'(bcd_of(m_buf[1])));
`endif
  endtask

  // Drive one cycle of strobes, let the edge happen, then compare #1 later.
  task automatic cycle(input bit r, input bit sel, input bit load, input bit cap);
    rst = r;
    if8.iAsrcSel = sel; if8.iALoad = load; if8.iOutBufSel = cap;
    if4.iAsrcSel = sel; if4.iALoad = load; if4.iOutBufSel = cap;
    @(posedge clk);
    model_edge(r, sel, load, cap);
    #1;
    check_all();
  endtask

  task automatic count_to(input int n);
    cycle(0, 0, 1, 0);
    for (int i = 0; i < n; i++) cycle(0, 1, 1, 0);
  endtask

  int pulses;
  int seen[$];
  bit seq_ok;

  initial begin
    if8.iAsrcSel = 1'b1; if8.iALoad = 1'b1; if8.iOutBufSel = 1'b1;
    if4.iAsrcSel = 1'b1; if4.iALoad = 1'b1; if4.iOutBufSel = 1'b1;
    #2;

    // Reset with every strobe high for two edges.
    cycle(1, 1, 1, 1);
    cycle(1, 1, 1, 1);
    check("rst_alt", 32'(if8.oAlt10), 32'd1);
    check("rst_buf", 32'(if8.oOutBuf), 32'd0);

    // Nominal controller sequence.
    pulses = 0;
    seq_ok = 1'b0;
    cycle(0, 0, 1, 0);
    for (int it = 0; it < 30; it++) begin
      if (!if8.oAlt10) begin
        seq_ok = 1'b1;
        break;
      end
      cycle(0, 0, 0, 1);
      if (if8.oOutValid) begin
        pulses++;
        seen.push_back(int'(if8.oOutBuf));
      end
      cycle(0, 1, 1, 0);
    end
    check("seq_done", 32'(seq_ok), 32'd1);
    check("seq_pulses", 32'(pulses), 32'd10);
    for (int i = 0; i < seen.size(); i++) check("seq_value", 32'(seen[i]), 32'(i));
    check("seq_capcnt", 32'(if8.oCapCnt), 32'd10);
    check("seq_alt_end", 32'(if8.oAlt10), 32'd0);

    // Simultaneous load and capture at A=5.
    cycle(1, 0, 0, 0);
    count_to(5);
    cycle(0, 1, 1, 1);
    check("sim_buf", 32'(if8.oOutBuf), 32'd5);
    check("sim_valid", 32'(if8.oOutValid), 32'd1);
    cycle(0, 0, 0, 1);
    check("sim_a", 32'(if8.oOutBuf), 32'd6);

    // Wrap past all-ones on the 8-bit instance; flag is sticky until reset.
    cycle(1, 0, 0, 0);
    count_to(255);
    check("wrap_pre", 32'(if8.oWrapErr), 32'd0);
    cycle(0, 1, 1, 0);
    check("wrap_set", 32'(if8.oWrapErr), 32'd1);
    cycle(0, 0, 0, 1);
    check("wrap_a0", 32'(if8.oOutBuf), 32'd0);
    cycle(0, 0, 1, 0);
    cycle(0, 1, 1, 0);
    check("wrap_sticky", 32'(if8.oWrapErr), 32'd1);
    cycle(1, 0, 0, 0);
    check("wrap_clr", 32'(if8.oWrapErr), 32'd0);

    // Capture counter saturation on the 4-bit instance.
    for (int i = 0; i < 20; i++) cycle(0, 0, 0, 1);
    check("sat_cnt4", 32'(if4.oCapCnt), 32'd15);
    check("sat_cnt8", 32'(if8.oCapCnt), 32'd20);

    // Clear-load from A=7.
    cycle(1, 0, 0, 0);
    count_to(7);
    cycle(0, 0, 0, 1);
    check("clr_pre", 32'(if8.oOutBuf), 32'd7);
    cycle(0, 0, 1, 0);
    cycle(0, 0, 0, 1);
    check("clr_a", 32'(if8.oOutBuf), 32'd0);

`ifdef COUNTER_DP_BCD_EN
    cycle(1, 0, 0, 0);
    count_to(207);
    cycle(0, 0, 0, 1);
    check("bcd_207", 32'(if8.oOutBcd), 32'h207);
    check("bcd_buf", 32'(if8.oOutBuf), 32'd207);
    cycle(1, 1, 1, 1);
    check("bcd_rst", 32'(if8.oOutBcd), 32'h000);
`endif

    // Random strobes with occasional mid-run reset.
    for (int i = 0; i < 3000; i++) begin
      cycle(($urandom_range(0, 59) == 0), 1'($urandom), 1'($urandom), 1'($urandom));
    end

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #2000000;
    $display("FAIL timeout: simulation did not finish, got running expected finished");
    $fatal(1);
  end

endmodule

`default_nettype wire
